// File: rtl/mult_issue_ctrl.sv
// Issue controller for one shared pipelined 64x64 multiplier: round-robin issue from two
// requesters, tag tracking alongside the multiplier pipe, credit-gated completion FIFO to the CDB.
module mult_issue_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [63:0]      req0_mplier,
    input  logic [63:0]      req0_mcand,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [63:0]      req1_mplier,
    input  logic [63:0]      req1_mcand,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    input  logic             flush,
    output logic             mul_start,
    output logic [63:0]      mul_mplier,
    output logic [63:0]      mul_mcand,
    input  logic             mul_done,
    input  logic [63:0]      mul_product,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [63:0]      cdb_value,
    input  logic             cdb_grant,
    output logic             busy,
    output logic             seq_err
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_CRD = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    // arbitration / issue
    logic             rr_ptr_r;
    logic             rr_ptr_n_s;
    logic [CNT_W:0]   used_s;
    logic             can_accept_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic [63:0]      sel_mplier_s;
    logic [63:0]      sel_mcand_s;
    logic [TAG_W-1:0] sel_tag_s;
    logic             mul_start_r;
    logic [63:0]      mul_mplier_r;
    logic [63:0]      mul_mcand_r;

    // tag pipe: kill marks an op squashed by flush whose result is still owed by the multiplier
    logic [NUM_STAGES:0] pipe_vld_r;
    logic [NUM_STAGES:0] pipe_kill_r;
    logic [TAG_W-1:0]    pipe_tag_r [NUM_STAGES+1];
    logic                head_vld_s;
    logic                head_occ_s;
    logic                complete_s;

    // completion FIFO (entry 0 is the head and drives the CDB directly)
    logic [TAG_W-1:0] fifo_tag_r   [FIFO_DEPTH];
    logic [63:0]      fifo_val_r   [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag_n_s [FIFO_DEPTH];
    logic [63:0]      fifo_val_n_s [FIFO_DEPTH];
    logic [CNT_W-1:0] fifo_cnt_r;
    logic [CNT_W-1:0] fifo_cnt_n_s;
    logic [CNT_W-1:0] wr_idx_s;
    logic             enq_s;
    logic             deq_s;
    logic             full_s;
    logic             overflow_s;

    // status
    logic [CNT_W-1:0] inflight_r;
    logic [CNT_W-1:0] inflight_n_s;
    logic             cdb_valid_r;
    logic             busy_r;
    logic             seq_err_r;
    logic             seq_bad_s;

    assign used_s       = {1'b0, fifo_cnt_r} + {1'b0, inflight_r};
    assign can_accept_s = (used_s < DEPTH_CRD) && !flush;
    assign accept_s     = grant0_s | grant1_s;

    // Round-robin grant between the two requesters, gated by available credit
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (can_accept_s) begin
            if (req0_valid && req1_valid) begin
                grant0_s = ~rr_ptr_r;
                grant1_s = rr_ptr_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Operand/tag mux for the winning requester
    always_comb begin
        sel_mplier_s = req0_mplier;
        sel_mcand_s  = req0_mcand;
        sel_tag_s    = req0_tag;
        if (grant1_s) begin
            sel_mplier_s = req1_mplier;
            sel_mcand_s  = req1_mcand;
            sel_tag_s    = req1_tag;
        end else begin
            sel_mplier_s = req0_mplier;
            sel_mcand_s  = req0_mcand;
            sel_tag_s    = req0_tag;
        end
    end

    // Priority passes to the other requester after any grant
    always_comb begin
        rr_ptr_n_s = rr_ptr_r;
        if (grant0_s) begin
            rr_ptr_n_s = 1'b1;
        end else if (grant1_s) begin
            rr_ptr_n_s = 1'b0;
        end else begin
            rr_ptr_n_s = rr_ptr_r;
        end
    end

    // Issue register toward the multiplier; operands hold when idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r     <= 1'b0;
            mul_start_r  <= 1'b0;
            mul_mplier_r <= 64'd0;
            mul_mcand_r  <= 64'd0;
        end else begin
            rr_ptr_r    <= rr_ptr_n_s;
            mul_start_r <= accept_s;
            if (accept_s) begin
                mul_mplier_r <= sel_mplier_s;
                mul_mcand_r  <= sel_mcand_s;
            end else begin
                mul_mplier_r <= mul_mplier_r;
                mul_mcand_r  <= mul_mcand_r;
            end
        end
    end

    // Tag pipe: entry 0 coincides with mul_start, entry NUM_STAGES with the matching mul_done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_vld_r  <= '0;
            pipe_kill_r <= '0;
            for (int i = 0; i <= NUM_STAGES; i++) begin
                pipe_tag_r[i] <= '0;
            end
        end else begin
            pipe_vld_r[0]  <= accept_s;
            pipe_kill_r[0] <= 1'b0;
            pipe_tag_r[0]  <= sel_tag_s;
            for (int i = 1; i <= NUM_STAGES; i++) begin
                pipe_tag_r[i] <= pipe_tag_r[i-1];
                if (flush) begin
                    pipe_vld_r[i]  <= 1'b0;
                    pipe_kill_r[i] <= pipe_vld_r[i-1] | pipe_kill_r[i-1];
                end else begin
                    pipe_vld_r[i]  <= pipe_vld_r[i-1];
                    pipe_kill_r[i] <= pipe_kill_r[i-1];
                end
            end
        end
    end

    assign head_vld_s = pipe_vld_r[NUM_STAGES];
    assign head_occ_s = pipe_vld_r[NUM_STAGES] | pipe_kill_r[NUM_STAGES];
    assign complete_s = head_vld_s & mul_done;
    assign enq_s      = complete_s & ~flush;
    assign deq_s      = cdb_valid_r & cdb_grant;
    assign full_s     = (fifo_cnt_r == DEPTH_CNT);
    assign overflow_s = enq_s & full_s & ~deq_s;
    assign seq_bad_s  = (head_occ_s ^ mul_done) | overflow_s;
    assign wr_idx_s   = deq_s ? (fifo_cnt_r - CNT_ONE) : fifo_cnt_r;

    // Shifting FIFO next state: pop shifts toward the head, push lands behind the survivors
    always_comb begin
        fifo_tag_n_s = fifo_tag_r;
        fifo_val_n_s = fifo_val_r;
        fifo_cnt_n_s = fifo_cnt_r;
        if (flush) begin
            fifo_cnt_n_s = '0;
        end else begin
            if (deq_s) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    fifo_tag_n_s[i] = fifo_tag_r[i+1];
                    fifo_val_n_s[i] = fifo_val_r[i+1];
                end
                fifo_cnt_n_s = wr_idx_s;
            end else begin
                fifo_cnt_n_s = fifo_cnt_r;
            end
            if (enq_s && !overflow_s) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx_s) begin
                        fifo_tag_n_s[i] = pipe_tag_r[NUM_STAGES];
                        fifo_val_n_s[i] = mul_product;
                    end else begin
                        fifo_tag_n_s[i] = fifo_tag_n_s[i];
                        fifo_val_n_s[i] = fifo_val_n_s[i];
                    end
                end
                fifo_cnt_n_s = wr_idx_s + CNT_ONE;
            end else begin
                fifo_cnt_n_s = fifo_cnt_n_s;
            end
        end
    end

    // Ops accepted but not yet returned by the multiplier
    always_comb begin
        inflight_n_s = inflight_r;
        if (flush) begin
            inflight_n_s = '0;
        end else begin
            case ({accept_s, complete_s})
                2'b10:   inflight_n_s = inflight_r + CNT_ONE;
                2'b01:   inflight_n_s = inflight_r - CNT_ONE;
                default: inflight_n_s = inflight_r;
            endcase
        end
    end

    // FIFO storage, counters and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_tag_r[i] <= '0;
                fifo_val_r[i] <= 64'd0;
            end
            fifo_cnt_r  <= '0;
            inflight_r  <= '0;
            cdb_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            seq_err_r   <= 1'b0;
        end else begin
            fifo_tag_r  <= fifo_tag_n_s;
            fifo_val_r  <= fifo_val_n_s;
            fifo_cnt_r  <= fifo_cnt_n_s;
            inflight_r  <= inflight_n_s;
            cdb_valid_r <= (fifo_cnt_n_s != '0);
            busy_r      <= (inflight_n_s != '0) || (fifo_cnt_n_s != '0) || accept_s;
            seq_err_r   <= seq_err_r | seq_bad_s;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign mul_start  = mul_start_r;
    assign mul_mplier = mul_mplier_r;
    assign mul_mcand  = mul_mcand_r;
    assign cdb_valid  = cdb_valid_r;
    assign cdb_tag    = fifo_tag_r[0];
    assign cdb_value  = fifo_val_r[0];
    assign busy       = busy_r;
    assign seq_err    = seq_err_r;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomized bench for mult_issue_ctrl: a behavioural multiplier drives mul_done, and a
// queue-based model of accepted-but-unretired ops predicts every output each cycle.
module tb_mult_issue_ctrl;

    localparam int NS  = 4;
    localparam int TW  = 6;
    localparam int DEP = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [63:0]   req0_mplier, req0_mcand, req1_mplier, req1_mcand;
    logic [TW-1:0] req0_tag, req1_tag, cdb_tag;
    logic          flush, mul_start, mul_done, cdb_valid, cdb_grant, busy, seq_err;
    logic [63:0]   mul_mplier, mul_mcand, mul_product, cdb_value;

    mult_issue_ctrl #(.NUM_STAGES(NS), .TAG_W(TW), .FIFO_DEPTH(DEP)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_mplier(req0_mplier), .req0_mcand(req0_mcand),
        .req0_tag(req0_tag), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_mplier(req1_mplier), .req1_mcand(req1_mcand),
        .req1_tag(req1_tag), .req1_ready(req1_ready),
        .flush(flush), .mul_start(mul_start), .mul_mplier(mul_mplier), .mul_mcand(mul_mcand),
        .mul_done(mul_done), .mul_product(mul_product),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_grant(cdb_grant),
        .busy(busy), .seq_err(seq_err)
    );

    always #5 clock = ~clock;

    // ops accepted and not yet taken by the CDB, in acceptance order
    typedef struct { logic [TW-1:0] tag; logic [63:0] prod; int rdy; } op_t;
    // results the multiplier still owes; orphan = issued before a reset
    typedef struct { int due; logic [63:0] prod; bit orphan; } mq_t;
    op_t out_q[$];
    mq_t mq[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          m_rr, m_start, m_seq, m_g0, m_g1, m_cdbv, inject_stray;
    logic [63:0] m_mplier, m_mcand;
    int          done_kind;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_done();
        done_kind   = 0;
        mul_done    = 1'b0;
        mul_product = 64'd0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            mul_done    = 1'b1;
            mul_product = mq[0].prod;
            done_kind   = mq[0].orphan ? 2 : 1;
            void'(mq.pop_front());
        end else if (inject_stray) begin
            mul_done    = 1'b1;
            mul_product = {$urandom, $urandom};
            done_kind   = 2;
        end
        inject_stray = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_mul_start"}, 64'(mul_start), 64'd0);
        check_eq({pfx, "_mul_mplier"}, mul_mplier, 64'd0);
        check_eq({pfx, "_mul_mcand"}, mul_mcand, 64'd0);
        check_eq({pfx, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
        check_eq({pfx, "_cdb_tag"}, 64'(cdb_tag), 64'd0);
        check_eq({pfx, "_cdb_value"}, cdb_value, 64'd0);
        check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
        check_eq({pfx, "_seq_err"}, 64'(seq_err), 64'd0);
    endtask

    // one clock cycle: check outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        bit          can;
        logic [63:0] p;
        @(negedge clock);
        can    = !flush && (out_q.size() < DEP);
        m_g0   = can && req0_valid && (!req1_valid || !m_rr);
        m_g1   = can && req1_valid && (!req0_valid || m_rr);
        m_cdbv = (out_q.size() > 0) && (out_q[0].rdy <= cyc);
        check_eq("req0_ready", 64'(req0_ready), 64'(m_g0));
        check_eq("req1_ready", 64'(req1_ready), 64'(m_g1));
        check_eq("mul_start", 64'(mul_start), 64'(m_start));
        check_eq("mul_mplier", mul_mplier, m_mplier);
        check_eq("mul_mcand", mul_mcand, m_mcand);
        check_eq("cdb_valid", 64'(cdb_valid), 64'(m_cdbv));
        if (m_cdbv) begin
            check_eq("cdb_tag", 64'(cdb_tag), 64'(out_q[0].tag));
            check_eq("cdb_value", cdb_value, out_q[0].prod);
        end
        check_eq("busy", 64'(busy), 64'(out_q.size() != 0));
        check_eq("seq_err", 64'(seq_err), 64'(m_seq));
        if (mul_start) begin
            p = mul_mplier * mul_mcand;
            mq.push_back('{cyc + NS, p, 1'b0});
        end
        @(posedge clock);
        if (m_cdbv && cdb_grant) void'(out_q.pop_front());
        if (done_kind == 2) m_seq = 1'b1;
        m_start = m_g0 || m_g1;
        if (m_g0) begin
            p = req0_mplier * req0_mcand;
            out_q.push_back('{req0_tag, p, cyc + NS + 2});
            m_mplier = req0_mplier;
            m_mcand  = req0_mcand;
            m_rr     = 1'b1;
        end else if (m_g1) begin
            p = req1_mplier * req1_mcand;
            out_q.push_back('{req1_tag, p, cyc + NS + 2});
            m_mplier = req1_mplier;
            m_mcand  = req1_mcand;
            m_rr     = 1'b0;
        end
        if (flush) out_q.delete();
        cyc++;
        #1;
        drive_done();
    endtask

    task automatic set_reqs(input int pct);
        req0_valid  = ($urandom_range(0, 99) < pct);
        req1_valid  = ($urandom_range(0, 99) < pct);
        req0_mplier = {$urandom, $urandom};
        req0_mcand  = {$urandom, $urandom};
        req1_mplier = {$urandom, $urandom};
        req1_mcand  = {$urandom, $urandom};
        req0_tag    = TW'($urandom);
        req1_tag    = TW'($urandom);
    endtask

    task automatic idle_steps(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        cdb_grant  = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // asynchronous reset asserted between edges; outputs must clear before the next edge
    task automatic mid_reset();
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        out_q.delete();
        m_rr = 1'b0; m_start = 1'b0; m_seq = 1'b0;
        m_mplier = 64'd0; m_mcand = 64'd0;
        foreach (mq[i]) mq[i].orphan = 1'b1;
        @(posedge clock);
        cyc++;
        #1;
        reset = 1'b1;
        drive_done();
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; cdb_grant = 1'b0; inject_stray = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_mplier = 64'd0; req0_mcand = 64'd0; req1_mplier = 64'd0; req1_mcand = 64'd0;
        req0_tag = '0; req1_tag = '0; mul_done = 1'b0; mul_product = 64'd0;
        m_rr = 1'b0; m_start = 1'b0; m_seq = 1'b0; m_mplier = 64'd0; m_mcand = 64'd0;
        done_kind = 0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        drive_done();

        // single op 3*5, tag 7
        cdb_grant = 1'b1;
        req0_valid = 1'b1; req0_mplier = 64'd3; req0_mcand = 64'd5; req0_tag = 6'd7;
        step();
        idle_steps(10);

        // both requesters streaming with the grant held
        for (int i = 0; i < 6; i++) begin
            set_reqs(100);
            if (i == 2) begin
                req0_mplier = 64'hFFFF_FFFF_FFFF_FFFF;
                req0_mcand  = 64'd2;
                req1_mplier = 64'hFFFF_FFFF_FFFF_FFFF;
                req1_mcand  = 64'd2;
            end
            step();
        end
        idle_steps(12);

        // CDB stalled: FIFO fills and acceptance stops, then drains
        cdb_grant = 1'b0;
        for (int i = 0; i < 14; i++) begin set_reqs(100); step(); end
        cdb_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin set_reqs(100); step(); end
        idle_steps(14);

        // three issues then a flush while they are still in the multiplier
        for (int i = 0; i < 3; i++) begin set_reqs(100); req1_valid = 1'b0; step(); end
        req0_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        idle_steps(12);

        // random traffic with occasional flush and CDB back-pressure
        for (int i = 0; i < 400; i++) begin
            set_reqs(60);
            cdb_grant = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 4);
            step();
        end
        idle_steps(16);

        // stray completion with nothing outstanding
        inject_stray = 1'b1;
        step();
        idle_steps(4);

        // fill the FIFO, then reset mid-stream; old results come back as orphans
        cdb_grant = 1'b0;
        for (int i = 0; i < 6; i++) begin set_reqs(100); step(); end
        mid_reset();
        idle_steps(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
